// File: rtl/vseq_pkg.sv
// Shared types and constants for the vector ALU sequencer.
// Holds the sequencer state encoding and the ALU control and flag widths.
package vseq_pkg;

    localparam int ALUC_W = 3;
    localparam int FLAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } vseq_state_e;

endpackage

// File: rtl/vec_alu_sequencer_lane_pick.sv
// lane_pick: combinational lowest-set-bit finder over a lane mask.
// Returns the index of the lowest set bit and whether any bit is set.
module lane_pick #(
    parameter int LANES = 4,
    parameter int IDXW  = $clog2(LANES)
) (
    input  logic [LANES-1:0] i_mask,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDXW'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: issues the active lanes of a vector op one per cycle to the shared ALU.
// Optional per-lane flag capture is built when VSEQ_FLAGS_EN is defined.
module vec_alu_sequencer
    import vseq_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int IDXW  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ALUC_W-1:0]       ALUControlIn,
    input  logic [LANES-1:0]        MaskIn,
    input  logic [LANES*DW-1:0]     VecA,
    input  logic [LANES*DW-1:0]     VecB,
    input  logic                    hold,
    input  logic [DW-1:0]           ALUResultS,
    input  logic [FLAG_W-1:0]       ALUFlagsS,
    output logic [DW-1:0]           Op1S,
    output logic [DW-1:0]           Op2S,
    output logic [ALUC_W-1:0]       ALUControlS,
    output logic                    issue,
    output logic                    StallDE,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*DW-1:0]     ResultV,
    output logic [LANES*FLAG_W-1:0] FlagsV,
    output vseq_state_e             o_state_dbg
);

    // Handshake: start is a request sampled only in IDLE; the op is taken on that edge.
    // issue is a valid strobe toward the ALU with no back-pressure other than hold,
    // and a lane is retired on every edge where issue is high.

    vseq_state_e          r_state;
    vseq_state_e          w_next_state;
    logic [IDXW-1:0]      r_idx;
    logic [LANES-1:0]     r_mask;
    logic [LANES*DW-1:0]  r_a;
    logic [LANES*DW-1:0]  r_b;
    logic [ALUC_W-1:0]    r_ctl;
    logic [LANES*DW-1:0]  r_result;

    logic [LANES-1:0]     w_mask_clr;
    logic [LANES-1:0]     w_pick_in;
    logic [IDXW-1:0]      w_pick_idx;
    logic                 w_pick_any;
    logic                 w_accept;
    logic                 w_capture;

    assign w_mask_clr = r_mask & ~(LANES'(1) << r_idx);
    assign w_pick_in  = (r_state == ST_IDLE) ? MaskIn : w_mask_clr;
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_capture  = (r_state == ST_RUN) && !hold;

    lane_pick #(
        .LANES (LANES),
        .IDXW  (IDXW)
    ) u_lane_pick (
        .i_mask (w_pick_in),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        issue        = 1'b0;
        StallDE      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        Op1S         = '0;
        Op2S         = '0;
        case (r_state)
            ST_IDLE: begin
                busy    = 1'b0;
                StallDE = start;
                if (start) begin
                    w_next_state = w_pick_any ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                StallDE = 1'b1;
                issue   = !hold;
                Op1S    = r_a[r_idx*DW +: DW];
                Op2S    = r_b[r_idx*DW +: DW];
                if (!hold && !w_pick_any) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Seeding the result with A makes masked-off lanes read back their source-A value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx    <= '0;
            r_mask   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ctl    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_idx    <= w_pick_idx;
            r_mask   <= MaskIn;
            r_a      <= VecA;
            r_b      <= VecB;
            r_ctl    <= ALUControlIn;
            r_result <= VecA;
        end else if (w_capture) begin
            r_idx                    <= w_pick_idx;
            r_mask                   <= w_mask_clr;
            r_result[r_idx*DW +: DW] <= ALUResultS;
        end
    end

    assign ALUControlS = r_ctl;
    assign ResultV     = r_result;
    assign o_state_dbg = r_state;

`ifdef VSEQ_FLAGS_EN
    logic [LANES*FLAG_W-1:0] r_flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else if (w_accept) begin
            r_flags <= '0;
        end else if (w_capture) begin
            r_flags[r_idx*FLAG_W +: FLAG_W] <= ALUFlagsS;
        end
    end

    assign FlagsV = r_flags;
`else
    logic w_unused_flags;

    assign w_unused_flags = ^ALUFlagsS;
    assign FlagsV         = '0;
`endif

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Self-checking bench for vec_alu_sequencer with an in-bench ALU and a lane-level reference model.
// Flag expectations follow VSEQ_FLAGS_EN the same way as the design.
module tb_vec_alu_sequencer;
    import vseq_pkg::*;

    localparam int LANES = 4;
    localparam int DW    = 32;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [2:0]           ALUControlIn = '0;
    logic [LANES-1:0]     MaskIn = '0;
    logic [LANES*DW-1:0]  VecA = '0;
    logic [LANES*DW-1:0]  VecB = '0;
    logic                 hold = 1'b0;
    logic [DW-1:0]        ALUResultS;
    logic [3:0]           ALUFlagsS;
    logic [DW-1:0]        Op1S;
    logic [DW-1:0]        Op2S;
    logic [2:0]           ALUControlS;
    logic                 issue;
    logic                 StallDE;
    logic                 busy;
    logic                 done;
    logic [LANES*DW-1:0]  ResultV;
    logic [LANES*4-1:0]   FlagsV;
    vseq_state_e          state_dbg;

    int n_vec = 0;
    int n_err = 0;

    vec_alu_sequencer #(.LANES(LANES), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUControlIn (ALUControlIn),
        .MaskIn       (MaskIn),
        .VecA         (VecA),
        .VecB         (VecB),
        .hold         (hold),
        .ALUResultS   (ALUResultS),
        .ALUFlagsS    (ALUFlagsS),
        .Op1S         (Op1S),
        .Op2S         (Op2S),
        .ALUControlS  (ALUControlS),
        .issue        (issue),
        .StallDE      (StallDE),
        .busy         (busy),
        .done         (done),
        .ResultV      (ResultV),
        .FlagsV       (FlagsV),
        .o_state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // ALU behaviour: {N,Z,C,V, result}; C is carry for ADD and not-borrow for SUB.
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        w = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[31:0];
                c = ~w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: r = a << b[4:0];
            default: r = a;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb {ALUFlagsS, ALUResultS} = alu_f(Op1S, Op2S, ALUControlS);

    function automatic logic [LANES*DW-1:0] rand_vec();
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    // driver + scoreboard: drives one vector op and checks it cycle by cycle
    task automatic run_op(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                          input logic [LANES-1:0] m, input logic [2:0] op,
                          input logic [31:0] hold_bits, input bit keep_start, output int lat);
        int                  exp_q[$];
        int                  n;
        int                  holds;
        int                  ln;
        bit                  got_done;
        logic [LANES*DW-1:0] exp_res;
        logic [LANES*4-1:0]  exp_flg;
        logic [35:0]         rf;
        exp_res = a;
        exp_flg = '0;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) begin
                exp_q.push_back(i);
                rf = alu_f(a[i*DW +: DW], b[i*DW +: DW], op);
                exp_res[i*DW +: DW] = rf[31:0];
                exp_flg[i*4 +: 4]   = rf[35:32];
            end
        end
`ifndef VSEQ_FLAGS_EN
        exp_flg = '0;
`endif
        lat = 0;
        VecA = a;
        VecB = b;
        MaskIn = m;
        ALUControlIn = op;
        start = 1'b1;
        hold = 1'b0;
        #1;
        n_vec++;
        if (StallDE !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_stall: got stall=%b busy=%b want stall=1 busy=0", StallDE, busy);
        end
        n = 0;
        holds = 0;
        got_done = 1'b0;
        while (!got_done && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            if (!keep_start) begin
                start = 1'b0;
            end else begin
                VecA = rand_vec();
                VecB = rand_vec();
                MaskIn = LANES'($urandom);
                ALUControlIn = 3'($urandom);
            end
            hold = (n < 32) ? hold_bits[n] : 1'b0;
            #1;
            if (exp_q.size() == 0) begin
                got_done = 1'b1;
                lat = n;
                n_vec++;
                if (done !== 1'b1 || busy !== 1'b1 || StallDE !== 1'b0 || issue !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_cycle: got done=%b busy=%b stall=%b issue=%b want 1 1 0 0",
                             done, busy, StallDE, issue);
                end
                n_vec++;
                if (Op1S !== '0 || Op2S !== '0) begin
                    n_err++;
                    $display("FAIL done_ops: got %h %h want 0 0", Op1S, Op2S);
                end
                n_vec++;
                if (n != $countones(m) + 1 + holds) begin
                    n_err++;
                    $display("FAIL latency: got %0d want %0d", n, $countones(m) + 1 + holds);
                end
                n_vec++;
                if (ResultV !== exp_res) begin
                    n_err++;
                    $display("FAIL result: got %h want %h", ResultV, exp_res);
                end
                n_vec++;
                if (FlagsV !== exp_flg) begin
                    n_err++;
                    $display("FAIL flags: got %h want %h", FlagsV, exp_flg);
                end
            end else begin
                ln = exp_q[0];
                n_vec++;
                if (done !== 1'b0 || busy !== 1'b1 || StallDE !== 1'b1 || issue !== !hold) begin
                    n_err++;
                    $display("FAIL run_ctrl: got done=%b busy=%b stall=%b issue=%b want 0 1 1 %b",
                             done, busy, StallDE, issue, !hold);
                end
                n_vec++;
                if (Op1S !== a[ln*DW +: DW] || Op2S !== b[ln*DW +: DW] || ALUControlS !== op) begin
                    n_err++;
                    $display("FAIL lane_ops: got %h %h %0d want %h %h %0d (lane %0d)", Op1S, Op2S,
                             ALUControlS, a[ln*DW +: DW], b[ln*DW +: DW], op, ln);
                end
                if (hold) holds++;
                else void'(exp_q.pop_front());
            end
        end
        if (!got_done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done want done within 64 cycles");
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE || ResultV !== exp_res) begin
            n_err++;
            $display("FAIL after_done: got done=%b busy=%b st=%0d res=%h want 0 0 0 %h",
                     done, busy, state_dbg, ResultV, exp_res);
        end
        n_vec++;
        if (StallDE !== start) begin
            n_err++;
            $display("FAIL idle_stall: got %b want %b", StallDE, start);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_vec++;
        if (state_dbg !== ST_IDLE || issue !== 1'b0 || StallDE !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got st=%0d iss=%b stall=%b busy=%b done=%b want all 0",
                     state_dbg, issue, StallDE, busy, done);
        end
        n_vec++;
        if (Op1S !== '0 || Op2S !== '0 || ALUControlS !== '0 || ResultV !== '0 || FlagsV !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h %h %0d %h %h want all 0", Op1S, Op2S, ALUControlS,
                     ResultV, FlagsV);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_add();
        int lat;
        run_op({32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10}, 4'b1111, 3'd0,
               32'd0, 1'b0, lat);
        n_vec++;
        if (ResultV !== {32'd44, 32'd33, 32'd22, 32'd11} || lat != 5) begin
            n_err++;
            $display("FAIL full_add: got %h lat %0d want 0000002c..0b lat 5", ResultV, lat);
        end
    endtask

    task automatic test_sparse_sub();
        int lat;
        run_op({32'd8, 32'd7, 32'd6, 32'd5}, {32'd1, 32'd1, 32'd1, 32'd1}, 4'b0101, 3'd1,
               32'd0, 1'b0, lat);
        n_vec++;
        if (ResultV !== {32'd8, 32'd6, 32'd6, 32'd4} || lat != 3) begin
            n_err++;
            $display("FAIL sparse_sub: got %h lat %0d want {8,6,6,4} lat 3", ResultV, lat);
        end
    endtask

    task automatic test_zero_mask();
        int                  lat;
        logic [LANES*DW-1:0] a;
        a = rand_vec();
        run_op(a, rand_vec(), 4'b0000, 3'd0, 32'd0, 1'b0, lat);
        n_vec++;
        if (ResultV !== a || lat != 1 || FlagsV !== '0) begin
            n_err++;
            $display("FAIL zero_mask: got %h lat %0d want %h lat 1", ResultV, lat, a);
        end
    endtask

    task automatic test_hold();
        int lat;
        // cycles 2 and 3 after start are lane 1, held twice
        run_op(rand_vec(), rand_vec(), 4'b1111, 3'd0, 32'b1100, 1'b0, lat);
        n_vec++;
        if (lat != 7) begin
            n_err++;
            $display("FAIL hold_latency: got %0d want 7", lat);
        end
    endtask

    task automatic test_top_lane();
        int lat;
        run_op(rand_vec(), rand_vec(), 4'b1000, 3'd4, 32'd0, 1'b0, lat);
        n_vec++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL top_lane: got lat %0d want 2", lat);
        end
    endtask

    task automatic test_flags_z();
        int                  lat;
        logic [LANES*DW-1:0] a;
        logic [LANES*DW-1:0] b;
        a = {32'd100, 32'd9, 32'd3, 32'd1};
        b = {32'd1, 32'd9, 32'd5, 32'd1};
        run_op(a, b, 4'b1111, 3'd1, 32'd0, 1'b0, lat);
        n_vec++;
`ifdef VSEQ_FLAGS_EN
        if (FlagsV[11:8] !== 4'b0110) begin
            n_err++;
            $display("FAIL flags_z: got lane2 %b want 0110", FlagsV[11:8]);
        end
`else
        if (FlagsV !== '0) begin
            n_err++;
            $display("FAIL flags_off: got %h want 0", FlagsV);
        end
`endif
    endtask

    task automatic test_abort();
        int lat;
        VecA = rand_vec();
        VecB = rand_vec();
        MaskIn = 4'b1111;
        ALUControlIn = 3'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_vec++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0 || done !== 1'b0 || issue !== 1'b0 ||
            StallDE !== 1'b0) begin
            n_err++;
            $display("FAIL abort_ctrl: got st=%0d busy=%b done=%b iss=%b stall=%b want all 0",
                     state_dbg, busy, done, issue, StallDE);
        end
        n_vec++;
        if (Op1S !== '0 || Op2S !== '0 || ALUControlS !== '0 || ResultV !== '0 || FlagsV !== '0) begin
            n_err++;
            $display("FAIL abort_data: got %h %h %0d %h %h want all 0", Op1S, Op2S, ALUControlS,
                     ResultV, FlagsV);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_done: got %b want 0", done);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op(rand_vec(), rand_vec(), 4'b1111, 3'd0, 32'd0, 1'b0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        // start held high through RUN and DONE: ignored there, taken in the next IDLE
        run_op(rand_vec(), rand_vec(), 4'b0110, 3'd2, 32'd0, 1'b1, lat);
        run_op(rand_vec(), rand_vec(), 4'b1011, 3'd1, 32'd0, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 24; t++) begin
            run_op(rand_vec(), rand_vec(), LANES'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   ($urandom & $urandom) & 32'h0000_03FE, 1'b0, lat);
        end
    endtask

    initial begin
        test_reset();
        test_full_add();
        test_sparse_sub();
        test_zero_mask();
        test_hold();
        test_top_lane();
        test_flags_z();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
